// File: rtl/rgb_pwm_controller.sv
// RGB LED driver: per-channel enable, PWM brightness and off/solid/blink/breathe
// modes. Configuration is captured on a load strobe; LED pins are registered.
//
// Breathe direction FSM
//   state   | meaning
//   BR_UP   | br_level ramps toward duty_r, one count per step tick
//   BR_DOWN | br_level ramps back toward 0, one count per step tick
module rgb_pwm_controller #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BLINK_FREQ = 60,
    parameter int N_CH       = 3,
    parameter int PWM_BITS   = 8
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                load,
    input  logic [1:0]          mode,
    input  logic [N_CH-1:0]     ch_en,
    input  logic [PWM_BITS-1:0] duty,
    output logic [N_CH-1:0]     led_out,
    output logic                blink_phase
);

    localparam int PRE_MAX = CLK_FREQ / (2 * BLINK_FREQ) - 1;
    localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRE_MAX);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SOLID   = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } br_state_t;

    logic [1:0]          mode_r;
    logic [N_CH-1:0]     en_r;
    logic [PWM_BITS-1:0] duty_r;

    logic [PRE_W-1:0]    pre_cnt;
    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_cnt;

    br_state_t           br_state;
    br_state_t           br_next;
    logic [PWM_BITS-1:0] br_level;
    logic [PWM_BITS-1:0] br_level_nxt;
    logic                br_active;

    logic                sel;

    assign step_tick = (pre_cnt == PRE_TOP);
    // Breathe runs only from a settled breathe config; any load restarts it.
    assign br_active = !load && (mode_r == MODE_BREATHE);

    // Configuration capture on the load strobe.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            mode_r <= MODE_OFF;
            en_r   <= '0;
            duty_r <= '0;
        end else if (load) begin
            mode_r <= mode;
            en_r   <= ch_en;
            duty_r <= duty;
        end
    end

    // Blink prescaler: wraps at PRE_MAX, toggling the phase and issuing a step.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            pre_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (step_tick) begin
            pre_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            pre_cnt     <= pre_cnt + PRE_W'(1);
        end
    end

    // Free-running PWM period counter, unaffected by load.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Breathe FSM state and level registers.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            br_state <= BR_UP;
            br_level <= '0;
        end else begin
            br_state <= br_next;
            br_level <= br_level_nxt;
        end
    end

    // Breathe FSM next state: turn around at the duty ceiling and at zero.
    always_comb begin
        br_next = br_state;
        if (!br_active) begin
            br_next = BR_UP;
        end else if (step_tick) begin
            case (br_state)
                BR_UP:   if (br_level >= duty_r) br_next = BR_DOWN;
                BR_DOWN: if (br_level == '0)     br_next = BR_UP;
                default: br_next = BR_UP;
            endcase
        end
    end

    // Breathe FSM output: level holds on a turnaround step, else moves by one.
    always_comb begin
        br_level_nxt = br_level;
        if (!br_active) begin
            br_level_nxt = '0;
        end else if (step_tick) begin
            case (br_state)
                BR_UP:   if (br_level < duty_r)  br_level_nxt = br_level + PWM_BITS'(1);
                BR_DOWN: if (br_level != '0)     br_level_nxt = br_level - PWM_BITS'(1);
                default: br_level_nxt = '0;
            endcase
        end
    end

    // Mode select of the PWM comparator result.
    always_comb begin
        sel = 1'b0;
        case (mode_r)
            MODE_OFF:     sel = 1'b0;
            MODE_SOLID:   sel = (pwm_cnt < duty_r);
            MODE_BLINK:   sel = (pwm_cnt < duty_r) && blink_phase;
            MODE_BREATHE: sel = (pwm_cnt < br_level);
            default:      sel = 1'b0;
        endcase
    end

    // Registered LED drive, gated per channel.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            led_out <= '0;
        end else begin
            led_out <= en_r & {N_CH{sel}};
        end
    end

endmodule

// File: tb/tb_rgb_pwm_controller.sv
// Bench for rgb_pwm_controller: small prescaler (10-cycle half period) and
// 4-bit PWM so the blink and breathe behaviour fits in short runs.
module tb_rgb_pwm_controller;

    localparam int HALF = 1200 / (2 * 60);  // cycles per blink half period
    localparam int PER  = 16;               // PWM period for 4-bit duty

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       load   = 1'b0;
    logic [1:0] mode   = 2'd0;
    logic [2:0] ch_en  = 3'd0;
    logic [3:0] duty   = 4'd0;
    logic [2:0] led_out;
    logic       blink_phase;

    int checks = 0;
    int errors = 0;

    rgb_pwm_controller #(
        .CLK_FREQ(1200), .BLINK_FREQ(60), .N_CH(3), .PWM_BITS(4)
    ) dut (
        .clk_in(clk_in), .reset(reset), .load(load), .mode(mode),
        .ch_en(ch_en), .duty(duty), .led_out(led_out), .blink_phase(blink_phase)
    );

    always #5 clk_in = ~clk_in;

    // Model: time since reset drives prescaler and PWM position; breathe
    // level is a triangle wave over the number of steps since the last load.
    bit       m_valid = 1'b0;
    int       m_t, m_mode, m_en, m_duty, m_steps;
    logic [2:0] m_led;
    logic     m_phase;

    function automatic int tri_level(int steps, int d);
        int p;
        p = steps % (2 * d + 2);
        return (p <= d) ? p : 2 * d + 1 - p;
    endfunction

    task automatic model_step();
        int pwm, lvl;
        bit ph, sel, tick;
        if (!reset) begin
            m_valid = 1'b1;
            m_t = 0; m_mode = 0; m_en = 0; m_duty = 0; m_steps = 0;
            m_led = 3'b000; m_phase = 1'b0;
        end else if (m_valid) begin
            pwm  = m_t % PER;
            ph   = ((m_t / HALF) % 2) == 1;
            lvl  = tri_level(m_steps, m_duty);
            case (m_mode)
                0: sel = 1'b0;
                1: sel = pwm < m_duty;
                2: sel = (pwm < m_duty) && ph;
                default: sel = pwm < lvl;
            endcase
            tick = (m_t % HALF) == HALF - 1;
            if (load) begin
                m_mode = int'(mode); m_en = int'(ch_en); m_duty = int'(duty);
                m_steps = 0;
            end else if (m_mode == 3 && tick) begin
                m_steps++;
            end
            m_t++;
            m_phase = ((m_t / HALF) % 2) == 1;
            m_led = sel ? 3'(m_en) : 3'b000;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    initial forever begin
        @(negedge clk_in);
        if (m_valid) begin
            check("led_out", 32'(led_out), 32'(m_led));
            check("blink_phase", 32'(blink_phase), 32'(m_phase));
        end
    end

    task automatic do_load(int md, int en, int d);
        load = 1'b1; mode = 2'(md); ch_en = 3'(en); duty = 4'(d);
        @(negedge clk_in);
        load = 1'b0;
    endtask

    task automatic count_win(input int n, output int c0, output int c1,
                             output int c2, output int cp);
        c0 = 0; c1 = 0; c2 = 0; cp = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            c0 += int'(led_out[0]);
            c1 += int'(led_out[1]);
            c2 += int'(led_out[2]);
            cp += int'(blink_phase);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, cp;

        // Reset beats load.
        reset = 1'b0; load = 1'b1; mode = 2'd1; ch_en = 3'b111; duty = 4'd15;
        repeat (5) @(negedge clk_in);
        check("rst_led", 32'(led_out), 0);
        check("rst_phase", 32'(blink_phase), 0);
        load = 1'b0; reset = 1'b1;
        count_win(20, c0, c1, c2, cp);
        check("idle_dark", c0 + c1 + c2, 0);

        // Solid, duty 4, channels 0 and 2.
        do_load(1, 3'b101, 4);
        @(negedge clk_in);
        count_win(PER, c0, c1, c2, cp);
        check("solid_ch0", c0, 4);
        check("solid_ch1", c1, 0);
        check("solid_ch2", c2, 4);

        // Duty boundaries.
        do_load(1, 3'b111, 0);
        @(negedge clk_in);
        count_win(PER, c0, c1, c2, cp);
        check("duty0_dark", c0 + c1 + c2, 0);
        do_load(1, 3'b111, 15);
        @(negedge clk_in);
        count_win(PER, c0, c1, c2, cp);
        check("dutymax_ch1", c1, 15);

        // Blink, duty max: 80-cycle window spans whole PWM and blink periods.
        do_load(2, 3'b111, 15);
        @(negedge clk_in);
        count_win(80, c0, c1, c2, cp);
        check("blink_ch0", c0, 37);
        check("blink_phase_hi", cp, 40);

        // Breathe, duty 3.
        do_load(3, 3'b111, 3);
        repeat (200) @(negedge clk_in);

        // Reload landing on a prescaler wrap.
        for (int i = 0; i < 2 * HALF && (m_t % HALF) != HALF - 1; i++)
            @(negedge clk_in);
        check("wrap_align", m_t % HALF, HALF - 1);
        do_load(3, 3'b111, 2);
        @(negedge clk_in);
        check("reload_dark", 32'(led_out), 0);
        repeat (150) @(negedge clk_in);

        // Reset in the middle of a lit blink phase.
        do_load(2, 3'b111, 15);
        for (int i = 0; i < 4 * HALF && led_out[0] !== 1'b1; i++)
            @(negedge clk_in);
        check("blink_lit", 32'(led_out[0]), 1);
        reset = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        check("midrst_led", 32'(led_out), 0);
        check("midrst_phase", 32'(blink_phase), 0);
        count_win(30, c0, c1, c2, cp);
        check("midrst_dark", c0 + c1 + c2, 0);

        do_load(1, 3'b010, 8);
        repeat (20) @(negedge clk_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_controller.md
Name: rgb_pwm_controller

Overview:
Parametrised multi-channel LED driver for the board's RGB LEDs. It adds per-block brightness (PWM duty) and four operating modes: off, solid, blink and breathe. Configuration is latched on a load strobe. Outputs are registered and drive the LED pins directly. A blink/step prescaler derived from the system clock sets the blink rate and the breathe ramp rate.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz
BLINK_FREQ, 60, blink square-wave frequency in Hz; also the breathe step rate ×2
N_CH, 3, number of LED channels (bit0 red, bit1 green, bit2 blue for the default)
PWM_BITS, 8, PWM counter and duty width

Ports:
clk_in  in  1  system clock
reset  in  1  synchronous, active-low reset
load  in  1  config strobe; latches mode, ch_en, duty when high at a clk_in edge
mode  in  2  0=off, 1=solid, 2=blink, 3=breathe
ch_en  in  N_CH  per-channel enable
duty  in  PWM_BITS  brightness; 0 = dark, 2^PWM_BITS-1 = max
led_out  out  N_CH  registered LED drive
blink_phase  out  1  current prescaler square-wave level

Behaviour:
Interface: reset is synchronous, active-low (asserted when reset==0); clock is clk_in. All state updates only on the posedge of clk_in.
- Reset (reset==0 at an edge) clears everything at that edge:
  - mode_r=0, en_r=0, duty_r=0
  - prescaler count=0, blink_phase=0
  - pwm_cnt=0
  - br_level=0, br_dir=up
  - led_out=0
  - Reset takes priority over load.
- Config: when load=1, mode_r/en_r/duty_r capture the inputs and are used from the next cycle. Any load also forces br_level=0 and br_dir=up. Prescaler and pwm_cnt are not disturbed by load.
- Prescaler:
  - PRE_MAX = CLK_FREQ/(2*BLINK_FREQ)-1; counter width = $clog2(PRE_MAX+1); PRE_MAX>=1 is required.
  - Counts 0..PRE_MAX. At PRE_MAX it wraps to 0, toggles blink_phase, and asserts an internal one-cycle step tick.
  - blink_phase period = 2*(PRE_MAX+1) cycles, 50% duty.
- PWM: pwm_cnt is a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0. Comparator on(level) = (pwm_cnt < level), so a level of L gives L high cycles per 2^PWM_BITS-cycle period.
- Breathe engine (updates only on step tick while mode_r==3; otherwise holds br_level=0, br_dir=up):
  - dir up: if br_level >= duty_r, set dir=down with level unchanged; else br_level+1.
  - dir down: if br_level == 0, set dir=up with level unchanged; else br_level-1.
  - With duty_r=0 the level stays 0 and the dir flag alternates harmlessly.
  - If duty_r is lowered below br_level by a load, the load reset makes this a non-issue.
- Output (registered, one-cycle latency from pwm_cnt/phase), led_out[i] = en_r[i] & sel:
  - mode 0: sel=0
  - mode 1: sel=on(duty_r)
  - mode 2: sel=on(duty_r) & blink_phase
  - mode 3: sel=on(br_level)
- Boundaries:
  - duty 0 gives a constant-low output.
  - duty max gives high for all but one cycle per PWM period.
  - Simultaneous prescaler wrap and load: blink_phase still toggles; breathe restarts at 0.
  - Reset mid-operation zeroes all outputs at that edge.

Test Plan:
- Reset held low 5 cycles with load=1 and mode=1 -> led_out=0, blink_phase=0; after release with no load, led_out stays 0.
- PWM_BITS=4. load mode=1, ch_en=3'b101, duty=4 -> over every 16-cycle window led_out[0] and led_out[2] are high exactly 4 cycles, led_out[1]=0.
- CLK_FREQ=1200, BLINK_FREQ=60 (PRE_MAX=9), mode=2, duty=15, PWM_BITS=4 -> blink_phase period 20 cycles. led_out is low whenever blink_phase=0, and high 15 of 16 PWM cycles while blink_phase=1.
- Same params, mode=3, duty=3 -> br_level sequence per step tick: 0,1,2,3,3(dir down),2,1,0,0(dir up),1…; led_out high-count per PWM period tracks br_level.
- Mid-breathe, load mode=3 with duty=2 -> br_level is 0 and dir up on the next cycle; blink_phase and pwm_cnt continue without a glitch.
- Drive reset=0 for one cycle in blink mode with led_out=1 -> led_out=0, blink_phase=0, mode_r=0 the following cycle; outputs remain 0 until a new load.
